// File: rtl/fix2float_pkg.sv
// -----------------------------------------------------------------------------
// fix2float_pkg
// Shared constants, FSM state type and exponent helper for the shared
// fixed-point to IEEE-754 single-precision conversion scheduler.
// -----------------------------------------------------------------------------
package fix2float_pkg;

  localparam int BIAS   = 127;
  localparam int EXP_W  = 8;
  localparam int MANT_W = 23;
  localparam int FIX_W  = 32;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ABS  = 3'd1,
    ST_NORM = 3'd2,
    ST_PACK = 3'd3,
    ST_DONE = 3'd4
  } f2f_state_t;

  // Biased exponent = BIAS + (FIX_W-1) - shift_cnt - fixpos, kept 9 bits wide.
  // With both operands at most 31 the result stays in 96..158, so bit 8 is
  // always clear and no denormal/overflow handling is needed.
  function automatic logic [EXP_W:0] pack_exp(input logic [4:0] shift_cnt,
                                              input logic [4:0] fixpos);
    logic [EXP_W:0] top;
    top = 9'(BIAS + FIX_W - 1);
    return top - {4'd0, shift_cnt} - {4'd0, fixpos};
  endfunction

endpackage

// File: rtl/fix2float_rr_arb.sv
// -----------------------------------------------------------------------------
// fix2float_rr_arb
// Round-robin arbiter: grants the first asserted request at or after i_ptr,
// searching modulo NREQ. Purely combinational.
//   i_req      : request vector, one bit per requester
//   i_ptr      : index with highest priority this cycle
//   i_en       : arbitration enable (no grant when low)
//   o_grant    : one-hot grant (all zero when nothing granted)
//   o_grant_id : encoded index of the granted requester
// -----------------------------------------------------------------------------
module fix2float_rr_arb #(
  parameter int NREQ = 2,
  parameter int ID_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [ID_W-1:0] i_ptr,
  input  logic            i_en,
  output logic [NREQ-1:0] o_grant,
  output logic [ID_W-1:0] o_grant_id
);

  // Rotating priority search starting at i_ptr; first hit wins.
  always_comb begin
    int   idx;
    logic found;
    o_grant    = '0;
    o_grant_id = '0;
    found      = 1'b0;
    idx        = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = int'(i_ptr) + i;
      if (idx >= NREQ) begin
        idx = idx - NREQ;
      end else begin
        idx = idx;
      end
      if (i_en && !found && i_req[idx]) begin
        o_grant[idx] = 1'b1;
        o_grant_id   = ID_W'(idx);
        found        = 1'b1;
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/fix2float_sched.sv
// -----------------------------------------------------------------------------
// fix2float_sched
// Shares one iterative fixed-to-float engine among NREQ requesters. A request
// is accepted in IDLE (one-hot o_req_ready pulse), converted through
// ABS -> NORM (one bit per cycle) -> PACK, and presented in DONE until the
// consumer takes it.
//   i_clk, i_rst   : clock, synchronous active-high reset
//   i_req_valid    : per-requester request valid
//   o_req_ready    : one-hot accept pulse, only ever high in IDLE
//   i_req_data     : NREQ x 32-bit two's-complement operands
//   i_req_fixpos   : NREQ x 5-bit binary-point positions
//   o_out_valid    : result valid (held in DONE)
//   i_out_ready    : consumer accept
//   o_out_result   : IEEE-754 single-precision result (truncated mantissa)
//   o_out_id       : index of the requester owning o_out_result
// -----------------------------------------------------------------------------
module fix2float_sched
  import fix2float_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int ID_W = $clog2(NREQ)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [NREQ-1:0]       i_req_valid,
  output logic [NREQ-1:0]       o_req_ready,
  input  logic [NREQ*FIX_W-1:0] i_req_data,
  input  logic [NREQ*5-1:0]     i_req_fixpos,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic [31:0]           o_out_result,
  output logic [ID_W-1:0]       o_out_id
);

  f2f_state_t         r_state;
  logic [ID_W-1:0]    r_ptr;
  logic [FIX_W-1:0]   r_data;
  logic [4:0]         r_fixpos;
  logic [ID_W-1:0]    r_id;
  logic               r_sign;
  logic [FIX_W-1:0]   r_mag;
  logic [4:0]         r_shift_cnt;
  logic [31:0]        r_result;
  logic               r_out_valid;

  logic               w_arb_en;
  logic [NREQ-1:0]    w_grant;
  logic [ID_W-1:0]    w_grant_id;
  logic [ID_W-1:0]    w_ptr_next;
  logic [FIX_W-1:0]   w_sel_data;
  logic [4:0]         w_sel_fixpos;
  logic [FIX_W-1:0]   w_abs;
  logic [EXP_W:0]     w_exp;
  logic               w_unused_bits;

  // Grants are suppressed outside IDLE and while reset is asserted, so
  // req_ready reads 0 during reset even though it is combinational.
  assign w_arb_en = (r_state == ST_IDLE) && !i_rst;

  fix2float_rr_arb #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_arb (
    .i_req      (i_req_valid),
    .i_ptr      (r_ptr),
    .i_en       (w_arb_en),
    .o_grant    (w_grant),
    .o_grant_id (w_grant_id)
  );

  assign o_req_ready = w_grant;

  assign w_ptr_next = (w_grant_id == ID_W'(NREQ - 1)) ? '0 : (w_grant_id + ID_W'(1));

  // One-hot AND-OR mux of the granted requester's operand and fixpos.
  always_comb begin
    w_sel_data   = '0;
    w_sel_fixpos = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_sel_data   = w_sel_data   | ({FIX_W{w_grant[i]}} & i_req_data[i*FIX_W +: FIX_W]);
      w_sel_fixpos = w_sel_fixpos | ({5{w_grant[i]}}     & i_req_fixpos[i*5 +: 5]);
    end
  end

  // 0x80000000 negates to itself, which is the correct unsigned magnitude.
  assign w_abs = r_data[FIX_W-1] ? (~r_data + 32'd1) : r_data;
  assign w_exp = pack_exp(r_shift_cnt, r_fixpos);

  // Bits dropped by mantissa truncation and the always-zero exponent MSB.
  assign w_unused_bits = ^{w_exp[EXP_W], r_mag[FIX_W-MANT_W-2:0]};

  // Conversion FSM and datapath registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_data      <= '0;
      r_fixpos    <= '0;
      r_id        <= '0;
      r_sign      <= 1'b0;
      r_mag       <= '0;
      r_shift_cnt <= '0;
      r_result    <= 32'd0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|w_grant) begin
            r_data   <= w_sel_data;
            r_fixpos <= w_sel_fixpos;
            r_id     <= w_grant_id;
            r_ptr    <= w_ptr_next;
            r_state  <= ST_ABS;
          end
        end
        ST_ABS: begin
          r_sign      <= r_data[FIX_W-1];
          r_shift_cnt <= 5'd0;
          if (w_abs == 32'd0) begin
            // Zero (either sign of input) always packs as +0.0.
            r_result    <= 32'd0;
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end else begin
            r_mag   <= w_abs;
            r_state <= ST_NORM;
          end
        end
        ST_NORM: begin
          if (r_mag[FIX_W-1]) begin
            r_state <= ST_PACK;
          end else begin
            r_mag       <= r_mag << 1;
            r_shift_cnt <= r_shift_cnt + 5'd1;
          end
        end
        ST_PACK: begin
          // Hidden bit is r_mag[31]; mantissa is the next 23 bits, truncated.
          r_result    <= {r_sign, w_exp[EXP_W-1:0], r_mag[FIX_W-2 -: MANT_W]};
          r_out_valid <= 1'b1;
          r_state     <= ST_DONE;
        end
        ST_DONE: begin
          if (i_out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_out_valid  = r_out_valid;
  assign o_out_result = r_result;
  assign o_out_id     = r_id;

endmodule

// File: tb/tb_fix2float_sched.sv
// -----------------------------------------------------------------------------
// tb_fix2float_sched
// Self-checking bench for fix2float_sched (NREQ=2): directed vector table,
// randomized conversions against an arithmetic reference, and hand-written
// sequences for arbitration, backpressure and mid-conversion reset.
// -----------------------------------------------------------------------------
module tb_fix2float_sched;

  localparam int NREQ = 2;
  localparam int ID_W = 1;

  logic               clk = 1'b0;
  logic               rst;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*32-1:0] req_data;
  logic [NREQ*5-1:0]  req_fixpos;
  logic               out_valid;
  logic               out_ready;
  logic [31:0]        out_result;
  logic [ID_W-1:0]    out_id;

  int n_pass  = 0;
  int n_total = 0;

  fix2float_sched #(.NREQ(NREQ), .ID_W(ID_W)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_req_data   (req_data),
    .i_req_fixpos (req_fixpos),
    .o_out_valid  (out_valid),
    .i_out_ready  (out_ready),
    .o_out_result (out_result),
    .o_out_id     (out_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic [31:0] data;
    logic [4:0]  fixpos;
    logic [31:0] exp_res;
    int          exp_lat;
  } vec_t;

  vec_t vecs[6];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: value = signed(data) / 2^fixpos, truncated to single precision.
  function automatic logic [31:0] ref_float(input logic [31:0] d, input logic [4:0] fp);
    longint v;
    longint m;
    longint mant;
    int     p;
    int     e;
    logic   s;
    v = $signed(d);
    s = (v < 0);
    m = s ? -v : v;
    if (m == 0) return 32'd0;
    p = 0;
    for (int i = 0; i < 32; i++) if (m[i]) p = i;
    e = 127 + p - int'(fp);
    if (p >= 23) mant = m >> (p - 23);
    else         mant = m << (23 - p);
    return {s, e[7:0], mant[22:0]};
  endfunction

  // Reference latency from acceptance cycle to out_valid.
  function automatic int ref_lat(input logic [31:0] d);
    longint v;
    longint m;
    int     p;
    v = $signed(d);
    m = (v < 0) ? -v : v;
    if (m == 0) return 2;
    p = 0;
    for (int i = 0; i < 32; i++) if (m[i]) p = i;
    return 4 + (31 - p);
  endfunction

  task automatic do_reset;
    rst       = 1'b1;
    req_valid = '0;
    out_ready = 1'b1;
    tick;
    tick;
    rst = 1'b0;
    #1;
  endtask

  task automatic set_req(input int idx, input logic [31:0] d, input logic [4:0] fp);
    req_data[idx*32 +: 32] = d;
    req_fixpos[idx*5 +: 5] = fp;
  endtask

  // Counts cycles from the current one until out_valid is seen (bounded).
  task automatic wait_out(output int lat);
    lat = 1;
    while (!out_valid && lat < 60) begin
      tick;
      lat++;
    end
  endtask

  // Single-requester conversion; caller starts in IDLE with out_ready=1.
  task automatic run_conv(input int idx, input logic [31:0] d, input logic [4:0] fp,
                          output logic [31:0] res, output int id, output int lat);
    int w;
    set_req(idx, d, fp);
    req_valid      = '0;
    req_valid[idx] = 1'b1;
    #1;
    w = 0;
    while (!req_ready[idx] && w < 20) begin
      tick;
      w++;
    end
    check("accept", 32'(req_ready[idx]), 32'd1);
    tick;
    req_valid = '0;
    wait_out(lat);
    res = out_result;
    id  = int'(out_id);
    tick;
  endtask

  initial begin
    logic [31:0] res;
    int          id;
    int          lat;
    int          w;
    logic [31:0] d;
    logic [4:0]  fp;
    int          idx;
    logic [31:0] hold_res;

    vecs[0] = '{0, 32'h00000100,  5'd8,  32'h3F800000, 27};
    vecs[1] = '{1, 32'hFFFFFE00,  5'd8,  32'hC0000000, 26};
    vecs[2] = '{0, 32'h80000000,  5'd0,  32'hCF000000, 4};
    vecs[3] = '{0, 32'h00000000,  5'd5,  32'h00000000, 2};
    vecs[4] = '{1, 32'h7FFFFFFF,  5'd0,  32'h4EFFFFFF, 5};
    vecs[5] = '{0, 32'h00000001,  5'd31, 32'h30000000, 35};

    req_data   = '0;
    req_fixpos = '0;
    out_ready  = 1'b1;

    // Reset state, with requests pending to show grants are held off.
    rst       = 1'b1;
    req_valid = 2'b11;
    tick;
    tick;
    check("rst_out_valid",  32'(out_valid),  32'd0);
    check("rst_out_result", out_result,      32'd0);
    check("rst_out_id",     32'(out_id),     32'd0);
    check("rst_req_ready",  32'(req_ready),  32'd0);
    do_reset;

    // Directed vectors.
    for (int i = 0; i < 6; i++) begin
      run_conv(vecs[i].idx, vecs[i].data, vecs[i].fixpos, res, id, lat);
      check("vec_result", res, vecs[i].exp_res);
      check("vec_id",     32'(id), 32'(vecs[i].idx));
      check("vec_lat",    32'(lat), 32'(vecs[i].exp_lat));
    end

    // Randomized conversions against the reference.
    for (int n = 0; n < 40; n++) begin
      idx = $urandom_range(0, 1);
      d   = $urandom;
      case ($urandom_range(0, 4))
        0: d = 32'd0;
        1: d = d >> $urandom_range(0, 31);
        2: d = $signed(d) >>> $urandom_range(0, 31);
        default: d = d;
      endcase
      fp = 5'($urandom_range(0, 31));
      run_conv(idx, d, fp, res, id, lat);
      check("rnd_result", res, ref_float(d, fp));
      check("rnd_id",     32'(id), 32'(idx));
      check("rnd_lat",    32'(lat), 32'(ref_lat(d)));
    end

    // Both requesters continuously valid: grants alternate 0,1,0,1.
    do_reset;
    set_req(0, 32'h00000003, 5'd0);
    set_req(1, 32'hFFFFFFF0, 5'd2);
    req_valid = 2'b11;
    #1;
    for (int n = 0; n < 4; n++) begin
      w = 0;
      while (req_ready == 2'b00 && w < 20) begin
        tick;
        w++;
      end
      check("alt_grant", 32'(req_ready), (n % 2 == 0) ? 32'd1 : 32'd2);
      if (n > 0) check("alt_next_accept", 32'(w), 32'd0);
      tick;
      check("alt_pulse_low", 32'(req_ready), 32'd0);
      wait_out(lat);
      check("alt_id", 32'(out_id), 32'(n % 2));
      check("alt_result", out_result,
            (n % 2 == 0) ? ref_float(32'h00000003, 5'd0) : ref_float(32'hFFFFFFF0, 5'd2));
      tick;
    end
    req_valid = '0;
    #1;

    // Backpressure: DONE held with outputs frozen and no grants.
    do_reset;
    set_req(0, 32'h00001234, 5'd4);
    set_req(1, 32'h00000040, 5'd1);
    out_ready = 1'b0;
    req_valid = 2'b01;
    #1;
    w = 0;
    while (!req_ready[0] && w < 20) begin
      tick;
      w++;
    end
    check("bp_accept", 32'(req_ready), 32'd1);
    tick;
    req_valid = 2'b11;
    wait_out(lat);
    check("bp_lat", 32'(lat), 32'(ref_lat(32'h00001234)));
    hold_res = ref_float(32'h00001234, 5'd4);
    for (int n = 0; n < 10; n++) begin
      tick;
      check("bp_valid",  32'(out_valid), 32'd1);
      check("bp_result", out_result,     hold_res);
      check("bp_id",     32'(out_id),    32'd0);
      check("bp_ready",  32'(req_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick;
    check("bp_release_valid", 32'(out_valid), 32'd0);
    check("bp_release_grant", 32'(req_ready), 32'd2);
    req_valid = '0;
    #1;

    // Reset during NORM after req1 was granted.
    do_reset;
    set_req(0, 32'h00000500, 5'd3);
    set_req(1, 32'h00000001, 5'd0);
    req_valid = 2'b10;
    #1;
    w = 0;
    while (!req_ready[1] && w < 20) begin
      tick;
      w++;
    end
    check("mr_accept1", 32'(req_ready), 32'd2);
    tick;
    req_valid = '0;
    tick;
    tick;
    rst       = 1'b1;
    req_valid = 2'b11;
    tick;
    check("mr_valid_low", 32'(out_valid), 32'd0);
    check("mr_ready_low", 32'(req_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("mr_ptr0_grant", 32'(req_ready), 32'd1);
    tick;
    req_valid = '0;
    wait_out(lat);
    check("mr_id",     32'(out_id),  32'd0);
    check("mr_result", out_result,   ref_float(32'h00000500, 5'd3));
    check("mr_lat",    32'(lat),     32'(ref_lat(32'h00000500)));
    tick;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/fix2float_sched.md
# fix2float_sched

Multi-requester scheduler that shares one iterative fixed-to-float conversion engine between `NREQ` clients. It arbitrates round-robin among valid requests, then sequences the conversion FSM: capture, absolute value, one-bit-per-cycle normalization, and IEEE-754 single-precision pack. It returns each result with the requester's ID over a valid/ready handshake. It sits between the fixed-point producers and the float consumer, and replaces per-client combinational converters.

## Interface
- `NREQ`, default 2: number of requesters, 2..8.
- `ID_W`, default `$clog2(NREQ)`: width of the requester ID.
- `clk`, input, 1: single clock; all logic is rising-edge.
- `rst`, input, 1: synchronous reset, active-high.
- `req_valid`, input, NREQ: request valid, one bit per requester.
- `req_ready`, output, NREQ: one-hot grant/accept pulse.
- `req_data`, input, NREQ*32: two's-complement fixed-point operand; requester i occupies `[32i+31:32i]`.
- `req_fixpos`, input, NREQ*5: binary-point position (fraction bits) for each requester.
- `out_valid`, output, 1: result valid.
- `out_ready`, input, 1: consumer accepts the result.
- `out_result`, output, 32: IEEE-754 single-precision result.
- `out_id`, output, ID_W: index of the requester that owns `out_result`.

## Operation
- **States:** IDLE, ABS, NORM, PACK, DONE.
- **IDLE**
  - If any `req_valid` is high, the arbiter grants the first valid index at or after `ptr`, searching modulo NREQ.
  - `req_ready[g]` is high combinationally in this cycle only. The handshake completes this cycle.
  - Latch `data`, `fixpos` and `id=g`; set `ptr <= (g+1) mod NREQ`; go to ABS.
- **ABS**
  - `sign = data[31]`; `mag = sign ? -data : data` (32-bit); `shift_cnt = 0`.
  - If `mag == 0`: `out_result = 0x00000000` with sign forced to 0; go to DONE.
  - Otherwise go to NORM.
- **NORM**
  - If `mag[31]`: go to PACK.
  - Otherwise `mag <= mag << 1` and `shift_cnt++`.
  - Dwell is k+1 cycles, where k is the leading-zero count (0..31).
- **PACK**
  - `exp = 127 + 31 - shift_cnt - fixpos`, computed in 9 bits.
  - Range is 96..158, so the result is never denormal or overflowed.
  - `mantissa = mag[30:8]`, truncated with no rounding.
  - `out_result = {sign, exp[7:0], mantissa}`; go to DONE.
- **DONE**
  - `out_valid = 1`; `out_result` and `out_id` hold stable.
  - On `out_valid && out_ready`, go to IDLE.
- Only one conversion is in flight. `req_ready` is 0 in every state except IDLE.
- `0x80000000`: negation yields `mag = 0x80000000`, which is a correct magnitude. The result is `sign=1`, `k=0`.
- Inputs that change after acceptance have no effect on the in-flight conversion.

## Timing
- **Reset values:** `out_valid=0`, `out_result=0`, `out_id=0`, `req_ready=0`, state=IDLE, `ptr=0`.
- **Reset mid-operation:**
  - The in-flight conversion is dropped and no output is produced for it.
  - On the next cycle the block is IDLE with `ptr=0`.
- **Latency:** with acceptance at cycle T, `out_valid` rises at T+4+k for a nonzero operand and at T+2 for zero.
- **Back-to-back:** the DONE handshake at cycle D lets the earliest next acceptance occur at D+1. That gives one bubble between results.
- **Backpressure:** `out_ready` low holds DONE indefinitely, with outputs frozen and no grants.
- **Simultaneous requests:**
  - Exactly one grant per acceptance cycle.
  - Rotation guarantees each continuously-valid requester a grant within NREQ conversions.
- `req_valid` dropping before grant withdraws the request; no state changes.

## Structure
- Package `fix2float_pkg` holds:
  - `BIAS=127`, `EXP_W=8`, `MANT_W=23`, `FIX_W=32`;
  - the state enum `f2f_state_t`.
- Sub-module `fix2float_rr_arb` is the round-robin arbiter:
  - inputs `req[NREQ]`, `ptr`, `en`;
  - outputs a one-hot `grant` and the encoded `grant_id`.
- The FSM and datapath live in `fix2float_sched`.

## Test plan
1. req0 `0x00000100`, fixpos 8 (value 1.0) → `out_result=0x3F800000`, `out_id=0`, `out_valid` at T+27 (k=23).
2. req1 `0xFFFFFE00`, fixpos 8 (−2.0) → `0xC0000000`, `out_id=1`. Also req0 `0x80000000`, fixpos 0 → `0xCF000000`, valid at T+4.
3. req0 `0x00000000`, fixpos 5 → `out_result=0x00000000`, `out_valid` at T+2.
4. Both `req_valid` held high with `out_ready=1` → grants alternate 0,1,0,1. Each `req_ready` is a one-cycle pulse with one bubble after each DONE handshake.
5. `out_ready` held low for 10 cycles in DONE → `out_valid`, `out_result` and `out_id` stable and no `req_ready` pulses. Release → IDLE next cycle.
6. Assert `rst` during NORM after req1 was granted → `out_valid=0` and `req_ready=0` next cycle. With both requesters valid afterwards, req0 is granted first (`ptr=0`).
